demux_stream: RTL and testbench

//  Parametrised, registered 1-to-N stream demultiplexer; successor to the 4-way 2-bit combinational demux.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_slot.sv | 37 +++
 rtl/demux_stream.sv | 90 +++++++++
 tb/tb_demux_stream.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // True when a select value addresses an existing channel.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_ch);
    return (sel < n_ch);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-word holding register with a valid flag.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_slot_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // A reload on the draining edge keeps the slot valid with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_slot_free = ~r_valid | i_ready;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast and a saturating
// counter of words discarded for an out-of-range channel select.
module demux_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int N_CH   = 4,
  parameter int SEL_W  = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [DROP_W-1:0]      drop_cnt
);

  logic [N_CH-1:0]   w_slot_free;
  logic [N_CH-1:0]   w_load;
  logic              w_in_range;
  logic              w_sel_free;
  logic              w_accept;
  logic              w_drop;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_in_range = sel_in_range(32'(in_sel), N_CH);

  // Free-slot status of the addressed channel (no match when out of range).
  always_comb begin
    w_sel_free = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel_free = w_sel_free | (w_slot_free[i] & (in_sel == SEL_W'(i)));
    end
  end

  // Broadcast waits for every slot; out-of-range words are always taken and dropped.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &w_slot_free;
    end else if (w_in_range) begin
      in_ready = w_sel_free;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign w_accept = in_valid & in_ready;
  assign w_drop   = w_accept & ~in_bcast & ~w_in_range;

  // One-hot load for unicast, all ones for broadcast.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_load[i] = w_accept & (in_bcast | (in_sel == SEL_W'(i)));
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load[g]),
      .i_data     (in_data),
      .i_ready    (out_ready[g]),
      .o_valid    (out_valid[g]),
      .o_data     (out_data[g*DATA_W +: DATA_W]),
      .o_slot_free(w_slot_free[g])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed and scoreboard checks for demux_stream (4-channel and 3-channel instances).
module tb_demux_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [1:0] in_sel;
  logic       in_bcast;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [7:0] drop_cnt;

  logic       d3_valid;
  logic       d3_in_ready;
  logic [1:0] d3_data;
  logic [1:0] d3_sel;
  logic       d3_bcast;
  logic [2:0] d3_out_valid;
  logic [2:0] d3_out_ready;
  logic [5:0] d3_out_data;
  logic [7:0] d3_drop;

  int total;
  int bad;

  logic [1:0] sb_q [4][$];

  demux_stream #(.DATA_W(2), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt)
  );

  demux_stream #(.DATA_W(2), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(d3_valid), .in_ready(d3_in_ready), .in_data(d3_data),
    .in_sel(d3_sel), .in_bcast(d3_bcast), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .drop_cnt(d3_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want %b", out_valid, 4'b0000); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want %b", in_ready, 1'b1); end
    step();
    out_ready = 4'b0000;
    in_valid  = 1'b1; in_sel = 2'd0; in_data = 2'b01;
    step();
    in_sel = 2'd2; in_data = 2'b10;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0101) begin bad++; $display("FAIL pre_reset_valid: got %b want %b", out_valid, 4'b0101); end
    total++; if (out_data !== 8'h21) begin bad++; $display("FAIL pre_reset_data: got %h want %h", out_data, 8'h21); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL async_reset_valid: got %b want %b", out_valid, 4'b0000); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL async_reset_data: got %h want %h", out_data, 8'h00); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL async_reset_drop: got %0d want %0d", drop_cnt, 0); end
    total++; if (d3_drop !== 8'd0) begin bad++; $display("FAIL async_reset_drop3: got %0d want %0d", d3_drop, 0); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    logic [1:0] v_data [4];
    logic [3:0] v_valid [4];
    logic [7:0] v_odata [4];
    v_data  = '{2'b00, 2'b01, 2'b01, 2'b11};
    v_valid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    v_odata = '{8'h00, 8'h04, 8'h14, 8'hD4};
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = v_data[k]; in_bcast = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready[%0d]: got %b want %b", k, in_ready, 1'b1); end
      step();
      total++; if (out_valid !== v_valid[k]) begin bad++; $display("FAIL uni_valid[%0d]: got %b want %b", k, out_valid, v_valid[k]); end
      total++; if (out_data !== v_odata[k]) begin bad++; $display("FAIL uni_data[%0d]: got %h want %h", k, out_data, v_odata[k]); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL uni_drained: got %b want %b", out_valid, 4'b0000); end
    total++; if (out_data !== 8'hD4) begin bad++; $display("FAIL uni_hold: got %h want %h", out_data, 8'hD4); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b10;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready: got %b want %b", in_ready, 1'b1); end
    step();
    total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bp_first_valid: got %b want %b", out_valid, 4'b0100); end
    in_data = 2'b11;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked: got %b want %b", in_ready, 1'b0); end
    step();
    total++; if (out_data[5:4] !== 2'b10) begin bad++; $display("FAIL bp_held: got %b want %b", out_data[5:4], 2'b10); end
    in_sel = 2'd1; in_data = 2'b01;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready: got %b want %b", in_ready, 1'b1); end
    step();
    total++; if (out_valid !== 4'b0110) begin bad++; $display("FAIL bp_other_valid: got %b want %b", out_valid, 4'b0110); end
    in_sel = 2'd2; in_data = 2'b11; out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want %b", in_ready, 1'b1); end
    step();
    total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bp_release_valid: got %b want %b", out_valid, 4'b0100); end
    total++; if (out_data !== 8'hF4) begin bad++; $display("FAIL bp_release_data: got %h want %h", out_data, 8'hF4); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 2'b01;
    step();
    out_ready = 4'b1110; in_bcast = 1'b1; in_data = 2'b10; in_sel = 2'd3;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked: got %b want %b", in_ready, 1'b0); end
    step();
    total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL bc_no_partial_valid: got %b want %b", out_valid, 4'b0001); end
    total++; if (out_data !== 8'hF5) begin bad++; $display("FAIL bc_no_partial_data: got %h want %h", out_data, 8'hF5); end
    out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_ready: got %b want %b", in_ready, 1'b1); end
    step();
    total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL bc_valid: got %b want %b", out_valid, 4'b1111); end
    total++; if (out_data !== 8'hAA) begin bad++; $display("FAIL bc_data: got %h want %h", out_data, 8'hAA); end
    in_valid = 1'b0; in_bcast = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    logic all_rdy;
    logic seen_valid;
    all_rdy = 1'b1; seen_valid = 1'b0;
    d3_out_ready = 3'b111; d3_bcast = 1'b0; d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 2'b01;
    for (int k = 0; k < 257; k++) begin
      #1;
      all_rdy = all_rdy & d3_in_ready;
      step();
      seen_valid = seen_valid | (|d3_out_valid);
      if (k == 0) begin
        total++; if (d3_drop !== 8'd1) begin bad++; $display("FAIL oor_first: got %0d want %0d", d3_drop, 1); end
      end
      if (k == 254 || k == 256) begin
        total++; if (d3_drop !== 8'd255) begin bad++; $display("FAIL oor_sat[%0d]: got %0d want %0d", k, d3_drop, 255); end
      end
    end
    total++; if (all_rdy !== 1'b1) begin bad++; $display("FAIL oor_ready: got %b want %b", all_rdy, 1'b1); end
    total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL oor_no_valid: got %b want %b", seen_valid, 1'b0); end
    d3_sel = 2'd2; d3_data = 2'b11;
    step();
    total++; if (d3_out_valid !== 3'b100) begin bad++; $display("FAIL oor_edge_valid: got %b want %b", d3_out_valid, 3'b100); end
    total++; if (d3_out_data[5:4] !== 2'b11) begin bad++; $display("FAIL oor_edge_data: got %b want %b", d3_out_data[5:4], 2'b11); end
    total++; if (d3_drop !== 8'd255) begin bad++; $display("FAIL oor_edge_drop: got %0d want %0d", d3_drop, 255); end
    d3_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_free;
    logic       exp_rdy;
    int         n_sent;
    int         n_recv;
    n_sent = 0; n_recv = 0;
    out_ready = 4'b1111; in_bcast = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 2'b01;
    step();
    in_data = 2'b10;
    step();
    total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL reload_valid: got %b want %b", out_valid, 4'b0001); end
    total++; if (out_data[1:0] !== 2'b10) begin bad++; $display("FAIL reload_data: got %b want %b", out_data[1:0], 2'b10); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reload_drain: got %b want %b", out_valid, 4'b0000); end
    for (int c = 0; c < 1003; c++) begin
      if (c < 1000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sel    = 2'($urandom_range(0, 3));
        in_bcast  = ($urandom_range(0, 7) == 0);
        in_data   = 2'($urandom_range(0, 3));
        out_ready = 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b1111;
      end
      #1;
      for (int i = 0; i < 4; i++) exp_free[i] = (sb_q[i].size() == 0) | out_ready[i];
      exp_rdy = in_bcast ? (&exp_free) : exp_free[in_sel];
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL sb_ready[c%0d]: got %b want %b", c, in_ready, exp_rdy); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sb_q[i].size() == 0) begin
          if (out_valid[i] !== 1'b0) begin bad++; $display("FAIL sb_dup[c%0d ch%0d]: got valid %b want %b", c, i, out_valid[i], 1'b0); end
        end else if (out_valid[i] !== 1'b1 || out_data[i*2 +: 2] !== sb_q[i][0]) begin
          bad++; $display("FAIL sb_word[c%0d ch%0d]: got %b/%b want 1/%b", c, i, out_valid[i], out_data[i*2 +: 2], sb_q[i][0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (sb_q[i].size() != 0 && out_ready[i]) begin
          void'(sb_q[i].pop_front());
          n_recv++;
        end
      end
      if (in_valid && exp_rdy) begin
        for (int i = 0; i < 4; i++) begin
          if (in_bcast || in_sel == 2'(i)) begin
            sb_q[i].push_back(in_data);
            n_sent++;
          end
        end
      end
      step();
    end
    total++; if (n_recv !== n_sent) begin bad++; $display("FAIL sb_count: got %0d want %0d", n_recv, n_sent); end
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL sb_final_valid: got %b want %b", out_valid, 4'b0000); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; in_data = 2'b00; in_sel = 2'd0; in_bcast = 1'b0; out_ready = 4'b0000;
    d3_valid = 1'b0; d3_data = 2'b00; d3_sel = 2'd0; d3_bcast = 1'b0; d3_out_ready = 3'b000;
    total = 0; bad = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
